// File: rtl/bits_detector_pll_pkg.sv
// rtl/bits_detector_pll_pkg.sv - shared width helpers, sample-select and lock-state encodings
package bits_detector_pkg;

  function automatic int corr_width(input int length);
    return $clog2(length + 1);
  endfunction

  function automatic int period_width(input int max_period);
    return $clog2(max_period + 1);
  endfunction

  // Index into the captured-score bank; one slot per early/late gate position
  typedef enum logic [1:0] {
    SEL_EARLY  = 2'd0,
    SEL_ONTIME = 2'd1,
    SEL_LATE   = 2'd2
  } sample_sel_e;

  localparam int NUM_SEL = 3;

  typedef enum logic {
    LK_UNLOCKED = 1'b0,
    LK_LOCKED   = 1'b1
  } lock_state_e;

endpackage

// File: rtl/bits_detector_pll_if.sv
// rtl/bits_detector_pll_if.sv - correlator-in / decided-bit-out bundle for bits_detector_pll
interface bits_detector_pll_if
  import bits_detector_pkg::*;
#(
  parameter int NSYM     = 4,
  parameter int CORR_W   = corr_width(16),
  parameter int PERIOD_W = period_width(64)
) ();

  localparam int SYM_W = $clog2(NSYM);

  logic                   restart;
  logic [PERIOD_W-1:0]    nominal_period;
  logic [NSYM*CORR_W-1:0] corr_dat;
  logic                   corr_vld;
  logic                   out_dat;
  logic                   out_vld;
  logic [SYM_W-1:0]       out_sym;
  logic                   locked;
  logic [PERIOD_W-1:0]    bit_period;

  modport master (
    output restart, nominal_period, corr_dat, corr_vld,
    input  out_dat, out_vld, out_sym, locked, bit_period
  );

  modport slave (
    input  restart, nominal_period, corr_dat, corr_vld,
    output out_dat, out_vld, out_sym, locked, bit_period
  );

endinterface

// File: rtl/bits_detector_pll_symbol_argmax.sv
// rtl/bits_detector_pll_symbol_argmax.sv - binary comparator tree: best score and its index
module symbol_argmax #(
  parameter int NSYM   = 4,
  parameter int CORR_W = 5
) (
  input  logic [NSYM*CORR_W-1:0]  i_scores,
  output logic [$clog2(NSYM)-1:0] o_idx,
  output logic [CORR_W-1:0]       o_max
);

  localparam int SYM_W = $clog2(NSYM);
  localparam int NLEAF = 1 << SYM_W;
  localparam int NNODE = 2 * NLEAF - 1;

  logic [CORR_W-1:0] w_val [NNODE];
  logic [SYM_W-1:0]  w_idx [NNODE];

  // Padding leaves sit right of every real symbol with score 0, so they never win a tie
  always_comb begin
    for (int n = 0; n < NNODE; n++) begin
      w_val[n] = '0;
      w_idx[n] = '0;
    end
    for (int i = 0; i < NLEAF; i++) begin
      w_idx[NLEAF-1+i] = SYM_W'(i);
    end
    for (int i = 0; i < NSYM; i++) begin
      w_val[NLEAF-1+i] = i_scores[i*CORR_W +: CORR_W];
    end
    for (int n = NLEAF - 2; n >= 0; n--) begin
      if (w_val[2*n+2] > w_val[2*n+1]) begin
        w_val[n] = w_val[2*n+2];
        w_idx[n] = w_idx[2*n+2];
      end else begin
        w_val[n] = w_val[2*n+1];
        w_idx[n] = w_idx[2*n+1];
      end
    end
  end

  assign o_idx = w_idx[0];
  assign o_max = w_val[0];

endmodule

// File: rtl/bits_detector_pll.sv
// rtl/bits_detector_pll.sv - early/late symbol timing recovery with bit decision and lock detect
// Define BITS_DETECTOR_LOCK_GATE_EN to suppress out_vld while unlocked.
module bits_detector_pll
  import bits_detector_pkg::*;
#(
  parameter int              NSYM           = 4,
  parameter int              LENGTH         = 16,
  parameter int              MAX_PERIOD     = 64,
  parameter int              DEFAULT_PERIOD = 16,
  parameter int              EL_GATES       = 1,
  parameter int              MAX_DEV        = 4,
  parameter logic [NSYM-1:0] SYMBOL_MAP     = 4'b1001,
  parameter int              LOCK_THRESH    = 12,
  parameter int              LOCK_COUNT     = 4,
  parameter int              UNLOCK_COUNT   = 2
) (
  input logic               clk,
  input logic               rst,
  bits_detector_pll_if.slave bus
);

  localparam int CORR_W   = corr_width(LENGTH);
  localparam int PERIOD_W = period_width(MAX_PERIOD);
  localparam int SYM_W    = $clog2(NSYM);
  localparam int VEC_W    = NSYM * CORR_W;
  localparam int CNT_MAX  = (LOCK_COUNT > UNLOCK_COUNT) ? LOCK_COUNT : UNLOCK_COUNT;
  localparam int LCNT_W   = $clog2(CNT_MAX + 1);
  localparam int EXT_W    = PERIOD_W + 1;

  typedef logic [EXT_W-1:0] ext_t;

  localparam ext_t EL_X    = ext_t'(EL_GATES);
  localparam ext_t DEV_X   = ext_t'(MAX_DEV);
  localparam ext_t HARD_LO = ext_t'(2 * EL_GATES + 2);
  localparam ext_t HARD_HI = ext_t'(MAX_PERIOD);

  logic [PERIOD_W-1:0] r_count;
  logic [PERIOD_W-1:0] r_period;
  logic [PERIOD_W-1:0] r_nominal;
  logic [VEC_W-1:0]    r_scores [NUM_SEL];
  logic                r_dec_pend;
  logic                r_late_pend;
  logic                r_dec_vld;
  logic                r_out_vld;
  logic                r_out_dat;
  logic [SYM_W-1:0]    r_out_sym;
  lock_state_e         r_lock_state;
  logic [LCNT_W-1:0]   r_good_cnt;
  logic [LCNT_W-1:0]   r_bad_cnt;
`ifdef BITS_DETECTOR_LOCK_GATE_EN
  logic                r_dec_lock;
`endif

  ext_t              w_period_x;
  ext_t              w_count_inc;
  logic              w_wrap;
  logic              w_late_hit;
  logic              w_early_hit;
  logic              w_ontime_hit;
  logic [SYM_W-1:0]  w_win_sym;
  logic [CORR_W-1:0] w_win_score;
  logic [CORR_W-1:0] w_sc_early;
  logic [CORR_W-1:0] w_sc_ontime;
  logic [CORR_W-1:0] w_sc_late;
  ext_t              w_step;
  ext_t              w_lo;
  ext_t              w_hi;
  ext_t              w_next_period;
  logic              w_good;
  logic [LCNT_W-1:0] w_good_inc;
  logic [LCNT_W-1:0] w_bad_inc;

  function automatic logic [CORR_W-1:0] sym_score(input logic [VEC_W-1:0] vec,
                                                  input logic [SYM_W-1:0] sym);
    return vec[sym*CORR_W +: CORR_W];
  endfunction

  // Wrap uses >= so a period that shrinks below the running count still ends the bit
  assign w_period_x   = {1'b0, r_period};
  assign w_count_inc  = {1'b0, r_count} + ext_t'(1);
  assign w_wrap       = w_count_inc >= w_period_x;
  assign w_late_hit   = bus.corr_vld && (r_count == PERIOD_W'(EL_GATES - 1));
  assign w_early_hit  = bus.corr_vld && ((w_count_inc + EL_X) == w_period_x);
  assign w_ontime_hit = bus.corr_vld && w_wrap;

  symbol_argmax #(
    .NSYM   (NSYM),
    .CORR_W (CORR_W)
  ) u_argmax (
    .i_scores (r_scores[SEL_ONTIME]),
    .o_idx    (w_win_sym),
    .o_max    (w_win_score)
  );

  assign w_sc_early  = sym_score(r_scores[SEL_EARLY],  r_out_sym);
  assign w_sc_ontime = sym_score(r_scores[SEL_ONTIME], r_out_sym);
  assign w_sc_late   = sym_score(r_scores[SEL_LATE],   r_out_sym);

  // Step toward the stronger gate, then clamp to the nominal window and the hard limits
  always_comb begin
    w_step = w_period_x;
    if (!(w_sc_ontime >= w_sc_early && w_sc_ontime >= w_sc_late)) begin
      if (w_sc_late >= w_sc_early) begin
        w_step = w_period_x + EL_X;
      end else begin
        w_step = (w_period_x > EL_X) ? (w_period_x - EL_X) : '0;
      end
    end
    w_lo = ({1'b0, r_nominal} > DEV_X) ? ({1'b0, r_nominal} - DEV_X) : '0;
    w_hi = {1'b0, r_nominal} + DEV_X;
    w_next_period = w_step;
    if (w_next_period < w_lo)    w_next_period = w_lo;
    if (w_next_period > w_hi)    w_next_period = w_hi;
    if (w_next_period < HARD_LO) w_next_period = HARD_LO;
    if (w_next_period > HARD_HI) w_next_period = HARD_HI;
  end

  assign w_good     = w_win_score >= CORR_W'(LOCK_THRESH);
  assign w_good_inc = (r_good_cnt == LCNT_W'(CNT_MAX)) ? r_good_cnt : r_good_cnt + LCNT_W'(1);
  assign w_bad_inc  = (r_bad_cnt  == LCNT_W'(CNT_MAX)) ? r_bad_cnt  : r_bad_cnt  + LCNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count      <= '0;
      r_period     <= PERIOD_W'(DEFAULT_PERIOD);
      r_nominal    <= PERIOD_W'(DEFAULT_PERIOD);
      for (int s = 0; s < NUM_SEL; s++) r_scores[s] <= '0;
      r_dec_pend   <= 1'b0;
      r_late_pend  <= 1'b0;
      r_dec_vld    <= 1'b0;
      r_out_vld    <= 1'b0;
      r_out_dat    <= SYMBOL_MAP[0];
      r_out_sym    <= '0;
      r_lock_state <= LK_UNLOCKED;
      r_good_cnt   <= '0;
      r_bad_cnt    <= '0;
`ifdef BITS_DETECTOR_LOCK_GATE_EN
      r_dec_lock   <= 1'b0;
`endif
    end else if (bus.restart) begin
      r_count      <= '0;
      r_period     <= bus.nominal_period;
      r_nominal    <= bus.nominal_period;
      for (int s = 0; s < NUM_SEL; s++) r_scores[s] <= '0;
      r_dec_pend   <= 1'b0;
      r_late_pend  <= 1'b0;
      r_dec_vld    <= 1'b0;
      r_out_vld    <= 1'b0;
      r_out_dat    <= SYMBOL_MAP[0];
      r_out_sym    <= '0;
      r_lock_state <= LK_UNLOCKED;
      r_good_cnt   <= '0;
      r_bad_cnt    <= '0;
`ifdef BITS_DETECTOR_LOCK_GATE_EN
      r_dec_lock   <= 1'b0;
`endif
    end else begin
      if (bus.corr_vld) begin
        r_count <= w_wrap ? '0 : r_count + PERIOD_W'(1);
      end
      if (w_early_hit)  r_scores[SEL_EARLY]  <= bus.corr_dat;
      if (w_ontime_hit) r_scores[SEL_ONTIME] <= bus.corr_dat;
      if (w_late_hit)   r_scores[SEL_LATE]   <= bus.corr_dat;

      r_dec_pend  <= w_ontime_hit;
      r_late_pend <= w_late_hit;
      r_dec_vld   <= 1'b0;
`ifdef BITS_DETECTOR_LOCK_GATE_EN
      r_out_vld   <= r_dec_vld & r_dec_lock;
`else
      r_out_vld   <= r_dec_vld;
`endif

      if (r_dec_pend) begin
        r_out_sym <= w_win_sym;
        r_out_dat <= SYMBOL_MAP[w_win_sym];
        r_dec_vld <= 1'b1;
`ifdef BITS_DETECTOR_LOCK_GATE_EN
        r_dec_lock <= (r_lock_state == LK_LOCKED);
`endif
        if (w_good) begin
          r_good_cnt <= w_good_inc;
          r_bad_cnt  <= '0;
          if (w_good_inc >= LCNT_W'(LOCK_COUNT)) r_lock_state <= LK_LOCKED;
        end else begin
          r_bad_cnt  <= w_bad_inc;
          r_good_cnt <= '0;
          if (w_bad_inc >= LCNT_W'(UNLOCK_COUNT)) r_lock_state <= LK_UNLOCKED;
        end
      end

      if (r_late_pend) begin
        r_period <= w_next_period[PERIOD_W-1:0];
      end
    end
  end

  assign bus.out_dat    = r_out_dat;
  assign bus.out_vld    = r_out_vld;
  assign bus.out_sym    = r_out_sym;
  assign bus.locked     = (r_lock_state == LK_LOCKED);
  assign bus.bit_period = r_period;

endmodule
